// File: rtl/alu_bist.sv
// alu_bist: built-in self-test engine for the RV32 ALU.
//
// Drives operand/opcode vectors into the ALU, waits ALU_LAT cycles, samples
// alu_out and compares it with an internal reference model. Every opcode
// gets 4 corner vectors followed by NUM_RANDOM LFSR vectors.
//
// Optional feature macro: ALU_BIST_ERRLOG_EN
//   defined   -> the first failing vector of a run is latched on fail_*
//   undefined -> fail_* are tied to 0 and no log registers exist
//
// Ports:
//   clk, rst_n (sync, active-low), start (run request)
//   alu_a, alu_b, alu_sel  : vector driven to the ALU
//   alu_out                : ALU result
//   busy, done, pass       : run status (done sticky until next start)
//   err_count, vec_count   : mismatch / checked-vector counters
//   fail_a/b/got/exp/sel   : first failing vector log
module alu_bist #(
  parameter int unsigned NUM_RANDOM = 16,
  parameter int unsigned ALU_LAT    = 1,
  parameter logic [31:0] SEED       = 32'hACE12024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] vec_count,
  output logic [31:0] fail_a,
  output logic [31:0] fail_b,
  output logic [31:0] fail_got,
  output logic [31:0] fail_exp,
  output logic [3:0]  fail_sel
);

  // Opcode encodings shared with the ALU
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;

  localparam int unsigned VPO = 4 + NUM_RANDOM;  // vectors per opcode
  localparam int VW = $clog2(VPO + 1);
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]     err_q, err_d, vec_q, vec_d;
  logic [31:0]     a_q, a_d, b_q, b_d, exp_q, exp_d, lfsr_q, lfsr_d;
  logic [3:0]      sel_q, sel_d, op_idx_q, op_idx_d;
  logic [VW-1:0]   vidx_q, vidx_d;
  logic [LW-1:0]   wait_q, wait_d;
  logic [31:0]     vec_a, vec_b;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Position in the run -> opcode
  function automatic logic [3:0] op_code(input logic [3:0] idx);
    case (idx)
      4'd0:    op_code = OP_ADD;
      4'd1:    op_code = OP_SUB;
      4'd2:    op_code = OP_SLL;
      4'd3:    op_code = OP_SLT;
      4'd4:    op_code = OP_SLTU;
      4'd5:    op_code = OP_XOR;
      4'd6:    op_code = OP_SRL;
      4'd7:    op_code = OP_SRA;
      4'd8:    op_code = OP_OR;
      4'd9:    op_code = OP_AND;
      default: op_code = OP_ADD;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  ref_alu = a + b;
      OP_SUB:  ref_alu = a - b;
      OP_SLL:  ref_alu = a << b[4:0];
      OP_SLT:  ref_alu = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: ref_alu = {31'b0, a < b};
      OP_XOR:  ref_alu = a ^ b;
      OP_SRL:  ref_alu = a >> b[4:0];
      OP_SRA:  ref_alu = $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   ref_alu = a | b;
      OP_AND:  ref_alu = a & b;
      default: ref_alu = 32'h0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    vec_d    = vec_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    exp_d    = exp_q;
    lfsr_d   = lfsr_q;
    op_idx_d = op_idx_q;
    vidx_d   = vidx_q;
    wait_d   = wait_q;
    vec_a    = 32'h0;
    vec_b    = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_DRIVE;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = 16'h0;
          vec_d    = 16'h0;
          op_idx_d = 4'd0;
          vidx_d   = '0;
          lfsr_d   = SEED_EFF;
        end
      end
      S_DRIVE: begin
        if (vidx_q < VW'(4)) begin
          case (vidx_q[1:0])
            2'd0:    begin vec_a = 32'h00000000; vec_b = 32'h00000000; end
            2'd1:    begin vec_a = 32'h7FFFFFFF; vec_b = 32'h00000001; end
            2'd2:    begin vec_a = 32'h80000000; vec_b = 32'hFFFFFFFF; end
            default: begin vec_a = 32'hFFFFFFFF; vec_b = 32'h0000001F; end
          endcase
        end else begin
          // One LFSR step per operand: a is the current state, b the next.
          vec_a  = lfsr_q;
          vec_b  = lfsr_step(lfsr_q);
          lfsr_d = lfsr_step(vec_b);
        end
        a_d     = vec_a;
        b_d     = vec_b;
        sel_d   = op_code(op_idx_q);
        exp_d   = ref_alu(op_code(op_idx_q), vec_a, vec_b);
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == LW'(ALU_LAT - 1)) state_d = S_CHECK;
        else                            wait_d  = wait_q + 1'b1;
      end
      S_CHECK: begin
        vec_d = vec_q + 16'd1;
        if (alu_out != exp_q) err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
        state_d = S_DRIVE;
        if (vidx_q == VW'(VPO - 1)) begin
          vidx_d = '0;
          if (op_idx_q == 4'd9) state_d  = S_DONE;
          else                  op_idx_d = op_idx_q + 4'd1;
        end else begin
          vidx_d = vidx_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 16'h0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 16'h0;
      vec_q    <= 16'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      sel_q    <= OP_ADD;
      exp_q    <= 32'h0;
      lfsr_q   <= 32'h0;
      op_idx_q <= 4'd0;
      vidx_q   <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      vec_q    <= vec_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      exp_q    <= exp_d;
      lfsr_q   <= lfsr_d;
      op_idx_q <= op_idx_d;
      vidx_q   <= vidx_d;
      wait_q   <= wait_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

`ifdef ALU_BIST_ERRLOG_EN
  logic [31:0] fa_q, fb_q, fgot_q, fexp_q;
  logic [3:0]  fsel_q;

  // err_q still zero on a mismatching CHECK marks the first failure of the run.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_q == S_IDLE && start)) begin
      fa_q   <= 32'h0;
      fb_q   <= 32'h0;
      fgot_q <= 32'h0;
      fexp_q <= 32'h0;
      fsel_q <= 4'h0;
    end else if (state_q == S_CHECK && alu_out != exp_q && err_q == 16'h0) begin
      fa_q   <= a_q;
      fb_q   <= b_q;
      fgot_q <= alu_out;
      fexp_q <= exp_q;
      fsel_q <= sel_q;
    end
  end

  assign fail_a   = fa_q;
  assign fail_b   = fb_q;
  assign fail_got = fgot_q;
  assign fail_exp = fexp_q;
  assign fail_sel = fsel_q;
`else
  assign fail_a   = 32'h0;
  assign fail_b   = 32'h0;
  assign fail_got = 32'h0;
  assign fail_exp = 32'h0;
  assign fail_sel = 4'h0;
`endif

endmodule

// File: doc/alu_bist.md
# alu_bist

Synthesizable built-in self-test engine for the RV32 ALU: drives the ALU's operand and opcode inputs, samples its result, and checks it against an internal reference model. Runs a fixed sequence of corner-case vectors plus LFSR pseudo-random vectors for every `alu_op.vh` opcode. Sits beside the ALU in the execute stage behind a test mux and reports pass/fail, error count and (optionally) the first failing vector.

## Interface
- `NUM_RANDOM`, 16: pseudo-random vectors per opcode after the 4 corner vectors.
- `ALU_LAT`, 1: cycles from operand drive to a valid `alu_out` (≥1).
- `SEED`, 32'hACE12024: LFSR load value on start; a value of 0 is replaced by 32'h1.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset, sampled on rising `clk`.
- `start` in 1: single-cycle run request.
- `alu_a` out 32: operand A to the ALU.
- `alu_b` out 32: operand B to the ALU.
- `alu_sel` out 4: opcode to the ALU, using `alu_op.vh` encodings.
- `alu_out` in 32: ALU result.
- `busy` out 1: run in progress.
- `done` out 1: run finished; sticky until the next accepted `start` or reset.
- `pass` out 1: valid when `done`; 1 if `err_count==0`.
- `err_count` out 16: mismatches; saturates at 16'hFFFF.
- `vec_count` out 16: vectors checked.
- `fail_a`, `fail_b`, `fail_got`, `fail_exp` out 32 each; `fail_sel` out 4: first failing vector (see Configuration).

## Operation
- Opcode order: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. V = 10·(4+NUM_RANDOM) vectors per run.
- Corner vectors, in order: (0,0), (7FFFFFFF,1), (80000000,FFFFFFFF), (FFFFFFFF,0000001F).
- Random vectors: 32-bit Galois LFSR, taps 32'h80200003, stepped once per operand; `a` takes the LFSR value, then `b` takes the next. LFSR is reloaded from `SEED` at every accepted start, so runs are deterministic.
- Reference model: all arithmetic mod 2^32. Shift amount is `b[4:0]`. SLT is signed and SLTU is unsigned; both yield 0 or 1. SRA is arithmetic.
- FSM states:
  - IDLE: on `start`, clear counters, `done` and the fail log, then go to DRIVE.
  - DRIVE: register `alu_a`/`alu_b`/`alu_sel` and the expected value.
  - WAIT: hold ALU_LAT cycles.
  - CHECK: compare `alu_out` with the expected value; increment `vec_count`; on mismatch increment `err_count`. Go to DRIVE for the next vector, or to DONE after the last one.
  - DONE: set `done` and `pass`, clear `busy`, go to IDLE.
- `start` while `busy` is ignored. `start` while `done` restarts the run.
- Reset at any time forces IDLE and all outputs to reset values. No partial results are retained.

## Timing
- Reset values: `busy`=`done`=`pass`=0; all counts, operands and fail fields are 0; `alu_sel`=`ADD`.
- `busy` rises the cycle after `start` is sampled in IDLE.
- Each vector takes ALU_LAT+2 cycles; operands are stable for the whole vector.
- `done` rises and `busy` falls V·(ALU_LAT+2)+1 cycles after `busy` rises, on the same edge.
- `err_count` and `vec_count` update on the CHECK edge.

## Configuration
- `ALU_BIST_ERRLOG_EN` defined: on the first mismatch of a run, latch `fail_sel`, `fail_a`, `fail_b`, `fail_got` (`alu_out`) and `fail_exp`. Later mismatches do not overwrite the log. The log is cleared on start.
- Undefined: the fail_* ports exist but are tied to 0, and the log registers are not built.

## Test plan
- Correct ALU model, NUM_RANDOM=0, ALU_LAT=1, pulse `start` -> `done` and `pass` both 1 exactly 121 cycles after `busy` rises; `vec_count`=40, `err_count`=0.
- Faulty ALU in which SUB returns a+b, NUM_RANDOM=0 -> `pass`=0, `err_count`=3. With `ALU_BIST_ERRLOG_EN`: `fail_sel`=SUB, `fail_a`=7FFFFFFF, `fail_b`=1, `fail_got`=80000000, `fail_exp`=7FFFFFFE.
- Faulty ALU in which SRA acts as SRL -> first failing vector is SRA on (80000000,FFFFFFFF) with `fail_exp`=FFFFFFFF and `fail_got`=00000001.
- `start` pulsed again mid-run -> ignored; `vec_count` at `done` is still 40.
- `rst_n` low for 1 cycle mid-run -> next cycle `busy`=0 and all counters are 0; a new `start` yields the same results as a fresh run.
- ALU_LAT=3, correct ALU, NUM_RANDOM=16 -> `done` after 200·5+1 cycles, `pass`=1; two consecutive runs produce an identical `alu_a`/`alu_b` sequence.
